// File: rtl/cpu6502_pkg.sv
// cpu6502_pkg: shared addressing-mode enum, length constants and decode state type.
package cpu6502_pkg;
  localparam int ADDR_W_DEF = 16;
  typedef enum logic [3:0] {
    M_IMP = 4'd0, M_ACC, M_IMM, M_ZP, M_ZPX, M_ZPY, M_REL,
    M_ABS, M_ABSX, M_ABSY, M_IND, M_INDX, M_INDY
  } mode_e;
  localparam logic [1:0] LEN1 = 2'd1, LEN2 = 2'd2, LEN3 = 2'd3;
  typedef enum logic [1:0] {S_OP, S_LO, S_HI} dec_state_e;
  function automatic logic [1:0] mode_len(input mode_e m);
    return (m == M_IMP || m == M_ACC) ? LEN1 :
           (m inside {M_ABS, M_ABSX, M_ABSY, M_IND}) ? LEN3 : LEN2;
  endfunction
endpackage

// File: rtl/opcode_decode_6502_if.sv
// opcode_decode_6502_if: fetch-byte input and assembled-instruction output bundle.
interface opcode_decode_6502_if import cpu6502_pkg::*; #(parameter int ADDR_W = ADDR_W_DEF);
  logic flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [7:0] in_byte, out_opcode;
  logic [ADDR_W-1:0] in_addr, out_pc, out_next_pc;
  logic [15:0] out_operand;
  mode_e out_mode;
  logic [1:0] out_len;
  modport master (
    output flush, in_valid, in_byte, in_addr, out_ready,
    input in_ready, out_valid, out_opcode, out_operand, out_mode, out_len, out_pc, out_next_pc, out_illegal
  );
  modport slave (
    input flush, in_valid, in_byte, in_addr, out_ready,
    output in_ready, out_valid, out_opcode, out_operand, out_mode, out_len, out_pc, out_next_pc, out_illegal
  );
endinterface

// File: rtl/opcode_class_6502.sv
// opcode_class_6502: combinational opcode -> {mode, len, illegal} lookup over the documented 6502 matrix.
module opcode_class_6502 import cpu6502_pkg::*; (
  input  logic [7:0] opcode,
  output mode_e      mode,
  output logic [1:0] len,
  output logic       illegal
);
  always_comb begin
    mode = M_IMP;
    illegal = 1'b0;
    case (opcode)
      8'h00, 8'h08, 8'h18, 8'h28, 8'h38, 8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h78, 8'h88, 8'h8A,
      8'h98, 8'h9A, 8'hA8, 8'hAA, 8'hB8, 8'hBA, 8'hC8, 8'hCA, 8'hD8, 8'hE8, 8'hEA, 8'hF8: mode = M_IMP;
      8'h0A, 8'h2A, 8'h4A, 8'h6A: mode = M_ACC;
      8'h09, 8'h29, 8'h49, 8'h69, 8'hA0, 8'hA2, 8'hA9, 8'hC0, 8'hC9, 8'hE0, 8'hE9: mode = M_IMM;
      8'h05, 8'h06, 8'h24, 8'h25, 8'h26, 8'h45, 8'h46, 8'h65, 8'h66, 8'h84, 8'h85, 8'h86,
      8'hA4, 8'hA5, 8'hA6, 8'hC4, 8'hC5, 8'hC6, 8'hE4, 8'hE5, 8'hE6: mode = M_ZP;
      8'h15, 8'h16, 8'h35, 8'h36, 8'h55, 8'h56, 8'h75, 8'h76, 8'h94, 8'h95, 8'hB4, 8'hB5,
      8'hD5, 8'hD6, 8'hF5, 8'hF6: mode = M_ZPX;
      8'h96, 8'hB6: mode = M_ZPY;
      8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0: mode = M_REL;
      8'h0D, 8'h0E, 8'h20, 8'h2C, 8'h2D, 8'h2E, 8'h4C, 8'h4D, 8'h4E, 8'h6D, 8'h6E, 8'h8C,
      8'h8D, 8'h8E, 8'hAC, 8'hAD, 8'hAE, 8'hCC, 8'hCD, 8'hCE, 8'hEC, 8'hED, 8'hEE: mode = M_ABS;
      8'h1D, 8'h1E, 8'h3D, 8'h3E, 8'h5D, 8'h5E, 8'h7D, 8'h7E, 8'h9D, 8'hBC, 8'hBD, 8'hDD,
      8'hDE, 8'hFD, 8'hFE: mode = M_ABSX;
      8'h19, 8'h39, 8'h59, 8'h79, 8'h99, 8'hB9, 8'hBE, 8'hD9, 8'hF9: mode = M_ABSY;
      8'h6C: mode = M_IND;
      8'h01, 8'h21, 8'h41, 8'h61, 8'h81, 8'hA1, 8'hC1, 8'hE1: mode = M_INDX;
      8'h11, 8'h31, 8'h51, 8'h71, 8'h91, 8'hB1, 8'hD1, 8'hF1: mode = M_INDY;
      default: illegal = 1'b1;
    endcase
  end
  assign len = mode_len(mode);
endmodule

// File: rtl/opcode_decode_6502.sv
// opcode_decode_6502: collects opcode + operand bytes from fetch and presents one
// assembled instruction per handshake; a non-contiguous operand byte restarts as an opcode.
module opcode_decode_6502 import cpu6502_pkg::*; #(parameter int ADDR_W = ADDR_W_DEF) (
  input logic clk,
  input logic rst_n,
  opcode_decode_6502_if.slave bus
);
  dec_state_e state, state_nx;
  logic [7:0] op_q, lo_q, ld_op;
  logic [ADDR_W-1:0] pc_q, last_addr, addr_inc, ld_pc;
  mode_e mode_q, c_mode, ld_mode;
  logic [1:0] len_q, c_len, ld_len;
  logic ill_q, c_ill, ld_ill, accept, as_op, load;
  logic [15:0] ld_operand;
  opcode_class_6502 u_class (.opcode(bus.in_byte), .mode(c_mode), .len(c_len), .illegal(c_ill));
  assign bus.in_ready = rst_n & ~bus.flush & (~bus.out_valid | bus.out_ready);
  assign accept = bus.in_valid & bus.in_ready;
  assign addr_inc = last_addr + 1'b1;
  // A gap in the address stream means a redirect happened upstream: treat the byte as a fresh opcode.
  assign as_op = state == S_OP || bus.in_addr != addr_inc;
  always_comb begin
    state_nx = state;
    if (bus.flush) state_nx = S_OP;
    else if (accept) state_nx = as_op ? (c_len == LEN1 ? S_OP : S_LO) :
                                (state == S_LO && len_q == LEN3) ? S_HI : S_OP;
    load = accept & (as_op ? c_len == LEN1 : (state == S_HI || len_q == LEN2));
    ld_op = as_op ? bus.in_byte : op_q;
    ld_mode = as_op ? c_mode : mode_q;
    ld_len = as_op ? c_len : len_q;
    ld_pc = as_op ? bus.in_addr : pc_q;
    ld_ill = as_op ? c_ill : ill_q;
    ld_operand = as_op ? 16'h0000 : state == S_HI ? {bus.in_byte, lo_q} : {8'h00, bus.in_byte};
  end
  always_ff @(posedge clk) state <= !rst_n ? S_OP : state_nx;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q <= '0;
      lo_q <= '0;
      pc_q <= '0;
      last_addr <= '0;
      mode_q <= M_IMP;
      len_q <= '0;
      ill_q <= 1'b0;
    end else if (accept) begin
      last_addr <= bus.in_addr;
      if (as_op) begin
        op_q <= bus.in_byte;
        pc_q <= bus.in_addr;
        mode_q <= c_mode;
        len_q <= c_len;
        ill_q <= c_ill;
      end else if (state == S_LO) lo_q <= bus.in_byte;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_opcode <= '0;
      bus.out_operand <= '0;
      bus.out_mode <= M_IMP;
      bus.out_len <= '0;
      bus.out_pc <= '0;
      bus.out_next_pc <= '0;
      bus.out_illegal <= 1'b0;
    end else if (bus.flush) bus.out_valid <= 1'b0;
    else if (load) begin
      bus.out_valid <= 1'b1;
      bus.out_opcode <= ld_op;
      bus.out_operand <= ld_operand;
      bus.out_mode <= ld_mode;
      bus.out_len <= ld_len;
      bus.out_pc <= ld_pc;
      bus.out_next_pc <= ld_pc + ADDR_W'(ld_len);
      bus.out_illegal <= ld_ill;
    end else if (bus.out_ready) bus.out_valid <= 1'b0;
  end
endmodule

// File: tb/tb_opcode_decode_6502.sv
// tb_opcode_decode_6502: table vectors, directed corner sequences and random traffic
// checked against a byte-queue reference model using the aaabbbcc opcode structure.
module tb_opcode_decode_6502;
  import cpu6502_pkg::*;
  typedef struct {logic [7:0] op; logic [15:0] operand; int mode; int len; logic [15:0] pc, npc; bit ill;} rec_t;
  typedef struct {logic [7:0] op; int mode; int len; bit ill;} vec_t;
  logic clk, rst_n;
  int checks, errors;
  logic [7:0] pend[$];
  logic [15:0] pend_pc, last_a;
  bit held, acc;
  rec_t hr;
  vec_t vt[14];
  opcode_decode_6502_if #(.ADDR_W(16)) bus();
  opcode_decode_6502 #(.ADDR_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void ref_class(input logic [7:0] op, output int mode, output bit ill);
    logic [2:0] a, b;
    a = op[7:5];
    b = op[4:2];
    mode = 0;
    ill = 0;
    case (op[1:0])
      2'b01: begin
        mode = (b == 0) ? 11 : (b == 1) ? 3 : (b == 2) ? 2 : (b == 3) ? 7 : (b == 4) ? 12 : (b == 5) ? 4 : (b == 6) ? 9 : 8;
        ill = op == 8'h89;
      end
      2'b10: case (b)
        0: begin mode = 2; ill = a != 5; end
        1: mode = 3;
        2: mode = a < 4 ? 1 : 0;
        3: mode = 7;
        4: ill = 1;
        5: mode = (a == 4 || a == 5) ? 5 : 4;
        6: ill = !(a == 4 || a == 5);
        default: begin mode = a == 5 ? 9 : 8; ill = a == 4; end
      endcase
      2'b00: case (b)
        0: begin mode = a == 1 ? 7 : a >= 5 ? 2 : 0; ill = a == 4; end
        1: begin mode = 3; ill = a == 0 || a == 2 || a == 3; end
        3: begin mode = a == 3 ? 10 : 7; ill = a == 0; end
        4: mode = 6;
        5: begin mode = 4; ill = !(a == 4 || a == 5); end
        7: begin mode = 8; ill = a != 5; end
        default: mode = 0;
      endcase
      default: ill = 1;
    endcase
    if (ill) mode = 0;
  endfunction

  function automatic int ref_len(input int mode);
    return mode <= 1 ? 1 : (mode >= 7 && mode <= 10) ? 3 : 2;
  endfunction

  task automatic model_byte(input logic [7:0] b, input logic [15:0] a);
    int m, n;
    bit il;
    if (pend.size() != 0 && a != 16'(last_a + 16'd1)) pend.delete();
    if (pend.size() == 0) pend_pc = a;
    pend.push_back(b);
    last_a = a;
    ref_class(pend[0], m, il);
    n = ref_len(m);
    if (pend.size() == n) begin
      hr.op = pend[0];
      hr.mode = m;
      hr.len = n;
      hr.ill = il;
      hr.pc = pend_pc;
      hr.npc = 16'(pend_pc + 16'(n));
      if (n == 1) hr.operand = 16'h0000;
      else if (n == 2) hr.operand = {8'h00, pend[1]};
      else hr.operand = {pend[2], pend[1]};
      held = 1;
      pend.delete();
    end
  endtask

  task automatic step(input logic f, input logic v, input logic [7:0] b, input logic [15:0] a, input logic r);
    bit rdy;
    bus.flush = f;
    bus.in_valid = v;
    bus.in_byte = b;
    bus.in_addr = a;
    bus.out_ready = r;
    #1;
    rdy = !f && (!held || r);
    chk("in_ready", bus.in_ready, rdy);
    chk("out_valid", bus.out_valid, held);
    if (held) begin
      chk("opcode", bus.out_opcode, hr.op);
      chk("operand", bus.out_operand, hr.operand);
      chk("mode", 32'(bus.out_mode), hr.mode);
      chk("len", bus.out_len, hr.len);
      chk("pc", bus.out_pc, hr.pc);
      chk("next_pc", bus.out_next_pc, hr.npc);
      chk("illegal", bus.out_illegal, hr.ill);
    end
    acc = v && rdy;
    @(posedge clk);
    if (f) begin
      pend.delete();
      held = 0;
    end else begin
      if (held && r) held = 0;
      if (acc) model_byte(b, a);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
  endtask

  task automatic expect_out(input string nm, input logic [7:0] op, input logic [15:0] operand, input int mode,
                            input int len, input logic [15:0] pc, input logic [15:0] npc, input bit ill);
    chk({nm, ".valid"}, bus.out_valid, 1);
    chk({nm, ".opcode"}, bus.out_opcode, op);
    chk({nm, ".operand"}, bus.out_operand, operand);
    chk({nm, ".mode"}, 32'(bus.out_mode), mode);
    chk({nm, ".len"}, bus.out_len, len);
    chk({nm, ".pc"}, bus.out_pc, pc);
    chk({nm, ".next_pc"}, bus.out_next_pc, npc);
    chk({nm, ".illegal"}, bus.out_illegal, ill);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.in_ready", bus.in_ready, 0);
    chk("rst.out_valid", bus.out_valid, 0);
    chk("rst.opcode", bus.out_opcode, 0);
    chk("rst.operand", bus.out_operand, 0);
    chk("rst.mode", 32'(bus.out_mode), 0);
    chk("rst.len", bus.out_len, 0);
    chk("rst.pc", bus.out_pc, 0);
    chk("rst.next_pc", bus.out_next_pc, 0);
    chk("rst.illegal", bus.out_illegal, 0);
    pend.delete();
    held = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] ra;
    int m, n;
    bit il;
    vt = '{'{8'h00, 0, 1, 0}, '{8'h0A, 1, 1, 0}, '{8'hA9, 2, 2, 0}, '{8'hA5, 3, 2, 0}, '{8'hB5, 4, 2, 0},
           '{8'hB6, 5, 2, 0}, '{8'hD0, 6, 2, 0}, '{8'h8D, 7, 3, 0}, '{8'hBD, 8, 3, 0}, '{8'hBE, 9, 3, 0},
           '{8'h6C, 10, 3, 0}, '{8'hA1, 11, 2, 0}, '{8'hB1, 12, 2, 0}, '{8'hFF, 0, 1, 1}};
    checks = 0;
    errors = 0;
    bus.in_byte = 8'h00;
    bus.in_addr = 16'h0000;
    do_reset();
    // test-plan sequences
    step(0, 1, 8'hA9, 16'h8000, 1);
    step(0, 1, 8'h42, 16'h8001, 1);
    expect_out("lda_imm", 8'hA9, 16'h0042, 2, 2, 16'h8000, 16'h8002, 0);
    step(0, 1, 8'h4C, 16'hC000, 1);
    step(0, 1, 8'h34, 16'hC001, 1);
    chk("jmp.early_valid", bus.out_valid, 0);
    step(0, 1, 8'h12, 16'hC002, 1);
    expect_out("jmp_abs", 8'h4C, 16'h1234, 7, 3, 16'hC000, 16'hC003, 0);
    step(0, 1, 8'hEA, 16'hFFFF, 1);
    expect_out("nop_wrap", 8'hEA, 16'h0000, 0, 1, 16'hFFFF, 16'h0000, 0);
    repeat (3) begin
      step(0, 1, 8'hA9, 16'h0000, 0);
      chk("stall.in_ready", bus.in_ready, 0);
      expect_out("stall", 8'hEA, 16'h0000, 0, 1, 16'hFFFF, 16'h0000, 0);
    end
    step(0, 0, 8'h00, 16'h0000, 1);
    chk("stall.drained", bus.out_valid, 0);
    step(0, 1, 8'hA9, 16'hFFFF, 1);
    step(0, 1, 8'h07, 16'h0000, 1);
    expect_out("addr_wrap", 8'hA9, 16'h0007, 2, 2, 16'hFFFF, 16'h0001, 0);
    step(0, 1, 8'h6C, 16'h9000, 1);
    step(0, 1, 8'h00, 16'h9001, 1);
    step(1, 1, 8'h02, 16'h9002, 1);
    chk("flush.no_out", bus.out_valid, 0);
    step(0, 1, 8'hE8, 16'hA000, 1);
    expect_out("inx", 8'hE8, 16'h0000, 0, 1, 16'hA000, 16'hA001, 0);
    idle();
    chk("inx.single", bus.out_valid, 0);
    step(0, 1, 8'hAD, 16'h8000, 1);
    step(0, 1, 8'h10, 16'h8001, 1);
    step(0, 1, 8'h20, 16'h9000, 1);
    step(0, 1, 8'h00, 16'h9001, 1);
    chk("jsr.no_lda", bus.out_valid, 0);
    step(0, 1, 8'h30, 16'h9002, 1);
    expect_out("jsr", 8'h20, 16'h3000, 7, 3, 16'h9000, 16'h9003, 0);
    step(0, 1, 8'h02, 16'h1234, 1);
    expect_out("ill_02", 8'h02, 16'h0000, 0, 1, 16'h1234, 16'h1235, 1);
    step(0, 1, 8'h89, 16'h5678, 1);
    expect_out("ill_89", 8'h89, 16'h0000, 0, 1, 16'h5678, 16'h5679, 1);
    idle();
    // reset mid-instruction: the following byte must decode as a new opcode
    step(0, 1, 8'h4C, 16'h0100, 1);
    step(0, 1, 8'h34, 16'h0101, 1);
    do_reset();
    step(0, 1, 8'h12, 16'h0102, 1);
    expect_out("post_rst", 8'h12, 16'h0000, 0, 1, 16'h0102, 16'h0103, 1);
    idle();
    // table-driven classification vectors
    for (int i = 0; i < 14; i++) begin
      ra = 16'h2000 + 16'(i * 16);
      step(0, 1, vt[i].op, ra, 1);
      if (vt[i].len > 1) step(0, 1, 8'h11, ra + 16'd1, 1);
      if (vt[i].len > 2) step(0, 1, 8'h22, ra + 16'd2, 1);
      expect_out("table", vt[i].op, vt[i].len == 1 ? 16'h0000 : vt[i].len == 2 ? 16'h0011 : 16'h2211,
                 vt[i].mode, vt[i].len, ra, ra + 16'(vt[i].len), vt[i].ill);
    end
    // every opcode back-to-back with out_ready high
    for (int op = 0; op < 256; op++) begin
      ra = 16'h6000 + 16'(op * 4);
      ref_class(8'(op), m, il);
      n = ref_len(m);
      step(0, 1, 8'(op), ra, 1);
      for (int k = 1; k < n; k++) step(0, 1, 8'(k * 17 + op), ra + 16'(k), 1);
    end
    idle();
    // random traffic: stalls, gaps, flushes
    ra = 16'h4000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) ra = 16'($urandom);
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 8'($urandom), ra, $urandom_range(0, 2) != 0);
      if (acc) ra++;
    end
    idle();
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/opcode_decode_6502.md
# opcode_decode_6502

Decode stage of the 6502 core. It sits directly downstream of the fetch stage and consumes the fetched byte stream, one byte per cycle, each byte tagged with its address. It classifies each opcode into an addressing mode and a length, collects the 0–2 operand bytes, and presents one assembled instruction per handshake to the execute stage. Pipeline redirects (jumps, branches, interrupts) discard partial state through `flush`.

## Interface
Parameters:
- `ADDR_W`, 16: width of byte addresses and PCs.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `flush`  in  1  discard any partial or held instruction (redirect).
- `in_valid`  in  1  fetch byte valid.
- `in_ready`  out  1  decode can accept the byte.
- `in_byte`  in  8  fetched byte.
- `in_addr`  in  ADDR_W  address of `in_byte`.
- `out_valid`  out  1  assembled instruction valid.
- `out_ready`  in  1  execute accepts the instruction.
- `out_opcode`  out  8  opcode byte.
- `out_operand`  out  16  `{hi,lo}`; `{8'h00,lo}` for 2-byte instructions; 0 for 1-byte instructions.
- `out_mode`  out  4  addressing mode (package enum).
- `out_len`  out  2  instruction length, 1–3.
- `out_pc`  out  ADDR_W  address of the opcode byte.
- `out_next_pc`  out  ADDR_W  `out_pc + out_len`, mod 2^ADDR_W.
- `out_illegal`  out  1  undocumented opcode.

## Operation
- Byte transfer occurs on a cycle with `in_valid & in_ready`. Instruction transfer occurs on a cycle with `out_valid & out_ready`.
- `in_ready = rst_n & ~flush & (~out_valid | out_ready)`. This is combinational; there is no skid buffer.
- FSM states:
  - OP: waiting for an opcode.
  - LO: waiting for operand low byte.
  - HI: waiting for operand high byte.
- Transitions:
  - OP + byte: look up mode and length. Length 1 → load the output register and stay in OP. Length 2/3 → go to LO.
  - LO + byte: length 2 → load the output register and go to OP. Length 3 → go to HI.
  - HI + byte: load the output register and go to OP.
- Continuity rule: in LO/HI, the operand byte must satisfy `in_addr == last_addr + 1` (mod 2^ADDR_W; 0xFFFF→0x0000 counts as continuous). On mismatch:
  - the partial instruction is dropped silently;
  - the byte is decoded as a new opcode, exactly as if received in OP.
- Opcode lookup follows the official 6502 matrix; all 151 documented opcodes are decoded.
  - Mode encoding: IMP=0, ACC=1, IMM=2, ZP=3, ZPX=4, ZPY=5, REL=6, ABS=7, ABSX=8, ABSY=9, IND=10, INDX=11, INDY=12.
  - Length: IMP/ACC → 1; IMM/ZP/ZPX/ZPY/REL/INDX/INDY → 2; ABS/ABSX/ABSY/IND → 3.
  - BRK (0x00) is IMP, length 1.
  - All 105 undocumented opcodes → `out_illegal=1`, IMP, length 1.
- `flush`:
  - FSM → OP; `out_valid` → 0 on the next edge.
  - A byte presented in the same cycle is not accepted (`in_ready` is 0).
  - `flush` has priority over all other events.
- Reset: FSM = OP. All outputs are 0: `out_valid`, `out_opcode`, `out_operand`, `out_mode`, `out_len`, `out_pc`, `out_next_pc`, `out_illegal`. `in_ready` is 0 while `rst_n` is low.

## Timing
- Latency: `out_valid` rises on the edge that accepts the last byte of an instruction. It is visible in the cycle after that byte's transfer.
- Throughput: one byte per cycle. A 1-byte instruction stream yields one instruction per cycle while `out_ready` is high.
- Back-pressure: while `out_valid & ~out_ready`:
  - all `out_*` are held stable;
  - `in_ready` = 0;
  - FSM and partial operand registers are frozen.
- Simultaneous `out_ready` and final-byte accept: the old instruction transfers and the new one is loaded on the same edge.
- Partial state is lost on reset asserted mid-instruction; no output is produced for the dropped instruction.

## Structure
- Shared package `cpu6502_pkg`:
  - addressing-mode enum (4 bits) and length constants;
  - `ADDR_W` default.
- Sub-module `opcode_class_6502`: purely combinational lookup from opcode to {mode, len, illegal}. It is reusable by disassembly and trace logic.
- Top module: FSM, operand registers, `last_addr`, output register, handshake logic.

## Test plan
- Bytes A9@0x8000, 42@0x8001 → one output: opcode A9, IMM, len 2, operand 0x0042, pc 0x8000, next_pc 0x8002, illegal 0.
- 4C@0xC000, 34@0xC001, 12@0xC002 → ABS, len 3, operand 0x1234, next_pc 0xC003. `out_valid` rises exactly one cycle after the 0x12 transfer.
- EA@0xFFFF with `out_ready` low for 3 cycles:
  - IMP, len 1, next_pc 0x0000;
  - outputs stable and `in_ready` 0 during the stall;
  - transfers on the 4th cycle.
- 6C@0x9000, 00@0x9001, then `flush` with 02@0x9002 → no output. Then E8@0xA000 → only INX is output (IMP, pc 0xA000).
- AD@0x8000, 10@0x8001, then 20@0x9000, 00@0x9001, 30@0x9002 → single output JSR: ABS, operand 0x3000, pc 0x9000.
- Opcodes 02 and 89, each at a fresh address → `out_illegal=1`, IMP, len 1, operand 0.
